// File: rtl/bridge_pkg.sv
// Shared types and constants for the darkriscv Wishbone bridge.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } bridge_state_t;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;

  // Access captured in IDLE and replayed on the bus; off/len are kept for read-back alignment.
  typedef struct packed {
    logic                 we;
    logic [NUM_LANES-1:0] sel;
    logic [2:0]           len;
    logic [1:0]           off;
    logic [31:0]          addr;
    logic [31:0]          data;
  } wb_req_t;

endpackage

// File: rtl/wb_lane_align.sv
// Combinational byte-lane steering between the LSB-justified core side and the 32-bit Wishbone bus.
module wb_lane_align
  import bridge_pkg::*;
(
  input  logic [2:0]           len,
  input  logic [1:0]           off,
  input  logic [31:0]          st_data,
  input  logic [31:0]          rd_raw,
  output logic [NUM_LANES-1:0] sel,
  output logic [31:0]          st_shift,
  output logic [31:0]          rd_align,
  output logic                 misaligned
);

  logic [NUM_LANES-1:0]             byte_en;
  logic [NUM_LANES-1:0][LANE_W-1:0] rd_lanes;

  // Unlisted sizes fall through to word handling.
  always_comb begin
    sel        = 4'b1111;
    byte_en    = 4'b1111;
    misaligned = |off;
    case (len)
      LEN_B: begin
        byte_en    = 4'b0001;
        sel        = 4'b0001 << off;
        misaligned = 1'b0;
      end
      LEN_H: begin
        byte_en    = 4'b0011;
        sel        = 4'b0011 << off;
        misaligned = off[0];
      end
      default: ;
    endcase
  end

  assign st_shift = st_data << {off, 3'b000};
  assign rd_lanes = rd_raw >> {off, 3'b000};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign rd_align[i*LANE_W +: LANE_W] = byte_en[i] ? rd_lanes[i] : '0;
  end

endmodule

// File: rtl/darkriscv_wb_bridge.sv
// darkriscv core bus to Wishbone classic master bridge (IDLE -> BUS -> RESP).
// Define BRIDGE_TIMEOUT_EN to abort BUS after TIMEOUT_CYCLES without ack.
module darkriscv_wb_bridge
  import bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [2:0]  cpu_len_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        cpu_hlt_o,
  output logic        cpu_berr_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i
);

  bridge_state_t state, state_nxt;
  wb_req_t       req_q;
  logic          cyc_q;

  logic [2:0]           lane_len;
  logic [1:0]           lane_off;
  logic [NUM_LANES-1:0] lane_sel;
  logic [31:0]          lane_st;
  logic [31:0]          lane_rd;
  logic                 lane_mis;

  logic any_req, start, err, done, timeout;

  // In BUS the lanes realign read data for the captured access, otherwise they decode the live request.
  assign lane_len = (state == BUS) ? req_q.len : cpu_len_i;
  assign lane_off = (state == BUS) ? req_q.off : cpu_addr_i[1:0];

  wb_lane_align u_lane (
    .len        (lane_len),
    .off        (lane_off),
    .st_data    (cpu_data_i),
    .rd_raw     (wb_data_i),
    .sel        (lane_sel),
    .st_shift   (lane_st),
    .rd_align   (lane_rd),
    .misaligned (lane_mis)
  );

  assign any_req = cpu_rd_i | cpu_wr_i;
  assign start   = (state == IDLE) && (cpu_rd_i ^ cpu_wr_i) && !lane_mis;
  assign err     = (state == IDLE) && any_req && !start;
  assign done    = (state == BUS) && (wb_ack_i || timeout);

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // An ack on the last allowed cycle still wins over the timeout.
  assign timeout = (state == BUS) && !wb_ack_i && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_core) begin
    if (rst_core)
      to_cnt <= '0;
    else if (start)
      to_cnt <= '0;
    else if (state == BUS)
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUS;
               else if (err) state_nxt = RESP;
      BUS:     if (done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state      <= IDLE;
      cyc_q      <= 1'b0;
      req_q      <= '0;
      cpu_data_o <= '0;
      cpu_berr_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      cpu_berr_o <= 1'b0;
      if (start) begin
        cyc_q      <= 1'b1;
        req_q.we   <= cpu_wr_i;
        req_q.sel  <= lane_sel;
        req_q.len  <= cpu_len_i;
        req_q.off  <= cpu_addr_i[1:0];
        req_q.addr <= {cpu_addr_i[31:2], 2'b00};
        req_q.data <= lane_st;
      end else if (err) begin
        cpu_berr_o <= 1'b1;
        cpu_data_o <= '0;
      end
      if (done) begin
        cyc_q      <= 1'b0;
        req_q.we   <= 1'b0;
        cpu_data_o <= wb_ack_i ? lane_rd : '0;
        cpu_berr_o <= !wb_ack_i;
      end
    end
  end

  // Stall covers the request cycle itself so the core holds its request until RESP.
  assign cpu_hlt_o = !rst_core && (((state == IDLE) && any_req) || (state == BUS));

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = req_q.we;
  assign wb_sel_o  = req_q.sel;
  assign wb_addr_o = req_q.addr;
  assign wb_data_o = req_q.data;

endmodule

// File: tb/tb_darkriscv_wb_bridge.sv
// Randomized bench for darkriscv_wb_bridge: transaction timeline model plus directed literal pins.
module tb_darkriscv_wb_bridge;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        cpu_rd_i, cpu_wr_i;
  logic [2:0]  cpu_len_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic        cpu_hlt_o, cpu_berr_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o, wb_data_o, wb_data_i;
  logic        wb_ack_i;

  darkriscv_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_core   (clk_core),
    .rst_core   (rst_core),
    .cpu_rd_i   (cpu_rd_i),
    .cpu_wr_i   (cpu_wr_i),
    .cpu_len_i  (cpu_len_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .cpu_hlt_o  (cpu_hlt_o),
    .cpu_berr_o (cpu_berr_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o),
    .wb_data_i  (wb_data_i),
    .wb_ack_i   (wb_ack_i)
  );

  always #5 clk_core = ~clk_core;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected per-cycle outputs, written only by the stimulus process.
  logic        chk_en = 1'b0;
  logic        exp_cyc, exp_hlt, exp_berr, exp_we;
  logic [3:0]  exp_sel;
  logic [31:0] exp_addr, exp_wdat, exp_data;

  // Literal pins handed to the compare process.
  logic        pin_valid = 1'b0;
  string       pin_nm;
  logic [31:0] pin_act, pin_exp;

  // Observations accumulated by the compare process.
  int          hlt_tot = 0, cyc_tot = 0, berr_tot = 0;
  logic [3:0]  last_sel;
  logic [31:0] last_wdat;
  logic        last_we;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk_core) begin
    if (chk_en) begin
      check("cyc",   32'(wb_cyc_o),   32'(exp_cyc));
      check("stb",   32'(wb_stb_o),   32'(exp_cyc));
      check("hlt",   32'(cpu_hlt_o),  32'(exp_hlt));
      check("berr",  32'(cpu_berr_o), 32'(exp_berr));
      check("rdata", cpu_data_o,      exp_data);
      if (exp_cyc) begin
        check("we",   32'(wb_we_o),  32'(exp_we));
        check("sel",  32'(wb_sel_o), 32'(exp_sel));
        check("addr", wb_addr_o,     exp_addr);
        check("wdat", wb_data_o,     exp_wdat);
      end
      if (wb_cyc_o) begin
        cyc_tot++;
        last_sel  = wb_sel_o;
        last_wdat = wb_data_o;
        last_we   = wb_we_o;
      end
      if (cpu_hlt_o)  hlt_tot++;
      if (cpu_berr_o) berr_tot++;
    end
    if (pin_valid) check(pin_nm, pin_act, pin_exp);
  end

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    pin_nm = nm; pin_act = act; pin_exp = exp; pin_valid = 1'b1;
    @(negedge clk_core);
    #1 pin_valid = 1'b0;
    @(posedge clk_core);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cpu_rd_i = 1'b0; cpu_wr_i = 1'b0;
      cpu_len_i = 3'($urandom_range(0, 7)); cpu_addr_i = $urandom; cpu_data_i = $urandom;
      wb_ack_i = 1'($urandom_range(0, 1)); wb_data_i = $urandom;
      exp_cyc = 1'b0; exp_hlt = 1'b0; exp_berr = 1'b0;
      step();
    end
  endtask

  // Drives one access from its request cycle through RESP; the core keeps its request up during RESP.
  task automatic txn(input logic rd, input logic wr, input logic [2:0] len, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input int dly);
    int          off, nbus;
    logic        mis, err, to;
    logic [3:0]  sel;
    logic [31:0] shr, res;
    off  = int'(addr[1:0]);
    mis  = (len == 3'd2 && addr[0]) || (len == 3'd4 && addr[1:0] != 2'b00);
    err  = (rd == wr) || mis;
    sel  = (len == 3'd1) ? 4'(4'b0001 << off) : (len == 3'd2) ? 4'(4'b0011 << off) : 4'hF;
    shr  = rdata >> (8 * off);
    res  = (len == 3'd1) ? (shr & 32'hFF) : (len == 3'd2) ? (shr & 32'hFFFF) : shr;
    cpu_rd_i = rd; cpu_wr_i = wr; cpu_len_i = len; cpu_addr_i = addr; cpu_data_i = wdata;
    wb_ack_i = 1'($urandom_range(0, 1)); wb_data_i = $urandom;
    exp_cyc = 1'b0; exp_hlt = 1'b1; exp_berr = 1'b0;
    step();
    if (err) begin
      exp_hlt = 1'b0; exp_berr = 1'b1; exp_data = 32'h0;
    end else begin
      nbus = dly + 1;
      to   = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      if (nbus > TO) begin nbus = TO; to = 1'b1; end
`endif
      exp_we = wr; exp_sel = sel; exp_addr = {addr[31:2], 2'b00}; exp_wdat = wdata << (8 * off);
      for (int i = 1; i <= nbus; i++) begin
        exp_cyc  = 1'b1; exp_hlt = 1'b1;
        wb_ack_i = (i == nbus) && !to;
        wb_data_i = wb_ack_i ? rdata : $urandom;
        step();
      end
      exp_cyc = 1'b0; exp_hlt = 1'b0; exp_berr = to; exp_data = to ? 32'h0 : res;
    end
    wb_ack_i = 1'($urandom_range(0, 1)); wb_data_i = $urandom;
    step();
  endtask

  initial begin
    int h0, c0, b0, kind;
    logic [2:0]  len;
    logic [31:0] addr;

    rst_core = 1'b1; cpu_rd_i = 1'b1; cpu_wr_i = 1'b0; cpu_len_i = 3'd4;
    cpu_addr_i = 32'h0; cpu_data_i = 32'h0; wb_ack_i = 1'b0; wb_data_i = 32'h0;
    @(posedge clk_core);
    #1;
    exp_cyc = 1'b0; exp_hlt = 1'b0; exp_berr = 1'b0; exp_data = 32'h0;
    exp_we = 1'b0; exp_sel = 4'h0; exp_addr = 32'h0; exp_wdat = 32'h0;
    chk_en = 1'b1;
    step();
    step();
    rst_core = 1'b0;
    idle(1);
    pin("rst_sel",  32'(wb_sel_o), 32'h0);
    pin("rst_addr", wb_addr_o,     32'h0);
    pin("rst_wdat", wb_data_o,     32'h0);
    pin("rst_we",   32'(wb_we_o),  32'h0);

    // Word load, single-cycle ack.
    h0 = hlt_tot;
    txn(1'b1, 1'b0, 3'd4, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    idle(1);
    pin("wload_data", cpu_data_o, 32'hDEADBEEF);
    pin("wload_sel",  32'(last_sel), 32'hF);
    pin("wload_hlt",  32'(hlt_tot - h0), 32'd2);

    // Byte store at the top lane.
    txn(1'b0, 1'b1, 3'd1, 32'h103, 32'h000000A5, $urandom, 0);
    idle(1);
    pin("bstore_sel",  32'(last_sel), 32'h8);
    pin("bstore_wdat", last_wdat,     32'hA5000000);
    pin("bstore_we",   32'(last_we),  32'h1);

    // Halfword load, upper half, slow slave.
    h0 = hlt_tot;
    txn(1'b1, 1'b0, 3'd2, 32'h202, 32'h0, 32'h1234ABCD, 5);
    idle(1);
    pin("hload_data", cpu_data_o, 32'h00001234);
    pin("hload_hlt",  32'(hlt_tot - h0), 32'd7);

    // Misaligned word load.
    c0 = cyc_tot; b0 = berr_tot;
    txn(1'b1, 1'b0, 3'd4, 32'h101, 32'h0, 32'h55555555, 0);
    idle(1);
    pin("mis_cyc",  32'(cyc_tot - c0),  32'd0);
    pin("mis_berr", 32'(berr_tot - b0), 32'd1);
    pin("mis_data", cpu_data_o, 32'h0);

    // Silent slave.
    c0 = cyc_tot; b0 = berr_tot;
`ifdef BRIDGE_TIMEOUT_EN
    txn(1'b1, 1'b0, 3'd4, 32'h400, 32'h0, 32'hCAFEF00D, 40);
    idle(1);
    pin("to_cyc",  32'(cyc_tot - c0),  32'd8);
    pin("to_berr", 32'(berr_tot - b0), 32'd1);
    pin("to_data", cpu_data_o, 32'h0);
`else
    txn(1'b1, 1'b0, 3'd4, 32'h400, 32'h0, 32'hCAFEF00D, 120);
    idle(1);
    pin("noto_cyc",  32'(cyc_tot - c0 > 100), 32'd1);
    pin("noto_berr", 32'(berr_tot - b0), 32'd0);
`endif

    // Reset on the second BUS cycle followed by a late ack.
    cpu_rd_i = 1'b1; cpu_wr_i = 1'b0; cpu_len_i = 3'd4; cpu_addr_i = 32'h800; wb_ack_i = 1'b0;
    exp_cyc = 1'b0; exp_hlt = 1'b1; exp_berr = 1'b0;
    step();
    exp_cyc = 1'b1; exp_we = 1'b0; exp_sel = 4'hF; exp_addr = 32'h800; exp_wdat = cpu_data_i;
    step();
    rst_core = 1'b1; exp_hlt = 1'b0;
    step();
    rst_core = 1'b0; cpu_rd_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h87654321;
    exp_cyc = 1'b0; exp_data = 32'h0;
    step();
    wb_ack_i = 1'b0;
    step();
    pin("rstbus_addr", wb_addr_o, 32'h0);
    pin("rstbus_data", cpu_data_o, 32'h0);

    // Random traffic, sometimes back-to-back.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      len  = ($urandom_range(0, 2) == 0) ? 3'd1 : ($urandom_range(0, 1) == 0) ? 3'd2 : 3'd4;
      addr = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (len == 3'd4) addr[1:0] = 2'b00;
        if (len == 3'd2) addr[0]   = 1'b0;
      end
      txn(kind == 0 || kind < 6, kind == 0 || kind >= 6, len, addr, $urandom, $urandom,
          ($urandom_range(0, 4) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
